stp_watch_ctrl: RTL and testbench
=================================

# stp_watch_ctrl

Control sequencer for the stopwatch timer. Turns the debounced start/stop and lap/reset buttons into a run/pause/lap/idle state machine. Generates the base count pulse that feeds the stopwatch seconds/minutes/hours counter chain, and issues the counter clear. Also drives the display lap-hold and latches counter-chain overflow.

## Interface
Parameters:
- TICK_DIV, 50_000_000: CLK cycles per count pulse; must be ≥ 2. Prescaler width is clog2(TICK_DIV).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_ss  in  1  start/stop, debounced level; the block detects its rising edge
- btn_lr  in  1  lap/reset, debounced level; the block detects its rising edge
- ovf  in  1  one-cycle pulse from the counter chain when the top counter wraps
- count_up_sec  out  1  one-cycle count pulse to the seconds counter
- rst_counters  out  1  one-cycle clear pulse to all stopwatch counters
- lap_hold  out  1  high while the display must freeze the lap value
- running  out  1  high in RUN or LAP
- ovf_flag  out  1  sticky overflow indicator
- state  out  2  IDLE=00, RUN=01, LAP=10, PAUSED=11

## Operation
- Edge detect:
  - btn_ss_q and btn_lr_q register the button levels; both reset to 0.
  - ss_e = btn_ss & ~btn_ss_q; lr_e = btn_lr & ~btn_lr_q.
  - A held button produces exactly one event.
- Event priority within a cycle: ovf (only while counting), then ss_e, then lr_e. A lower-priority event in the same cycle is discarded.
- Transitions:
  - IDLE: ss_e → RUN. lr_e → stays IDLE and pulses rst_counters.
  - RUN: ss_e → PAUSED. lr_e → LAP.
  - LAP: ss_e → PAUSED. lr_e → RUN.
  - PAUSED:
    - ss_e → RUN if ovf_flag=0; ignored if ovf_flag=1.
    - lr_e → IDLE and pulses rst_counters.
  - RUN or LAP with ovf=1 → PAUSED, and ovf_flag sets.
- Outputs:
  - lap_hold = (state==LAP).
  - running = (state==RUN || state==LAP).
- Prescaler presc:
  - Increments each cycle while running; wraps from TICK_DIV-1 to 0.
  - Holds its value in PAUSED, so a resume continues the partial period.
  - Forced to 0 in IDLE.
- count_up_sec = running && presc==TICK_DIV-1. It is combinational from registers and is never asserted outside RUN or LAP.
- rst_counters:
  - Registered; high for exactly the one cycle after the edge that took PAUSED → IDLE, or that saw lr_e in IDLE.
  - ovf_flag clears on the same edge that sets rst_counters.
- ovf in IDLE or PAUSED is ignored.

## Timing
- Reset values: state=IDLE, presc=0, rst_counters=0, ovf_flag=0, lap_hold=0, running=0, count_up_sec=0, btn_*_q=0.
- Button latency: the button goes high before edge k; state changes at edge k and is visible in the cycle after edge k.
- First pulse after start: entering RUN at edge k gives presc=0 in cycle k. count_up_sec is high in cycle k+TICK_DIV-1, then every TICK_DIV cycles after that.
- RUN↔LAP transitions do not disturb presc or the pulse cadence.
- Pause on a tick cycle: if ss_e occurs in the cycle where count_up_sec=1, that pulse is still emitted. presc wraps to 0 on the same edge that enters PAUSED.
- ovf entering PAUSED: presc updates normally on that edge; no further pulses follow.
- Mid-operation reset: rst_n low forces all reset values immediately, without waiting for CLK. No rst_counters pulse is generated; the counters see rst_n directly.

## Test plan
- TICK_DIV=4. Reset, then btn_ss high for 10 cycles → one event only; state=01; count_up_sec high in the 4th, 8th and 12th cycles after entry.
- In RUN with presc=2, press btn_ss → PAUSED, count_up_sec stays low. Wait 20 cycles, press btn_ss → RUN; first pulse comes 1 cycle after re-entry (presc resumes from 3).
- In RUN press btn_lr → state=10 with lap_hold=1, pulse cadence unchanged. Press btn_lr again → state=01 with lap_hold=0.
- In PAUSED press btn_lr → state=00, rst_counters high for exactly 1 cycle, presc=0. In IDLE press btn_lr → another single rst_counters pulse, state stays 00.
- In RUN assert ovf together with a btn_ss edge → PAUSED and ovf_flag=1. Next btn_ss is ignored; btn_lr → IDLE, rst_counters pulse, ovf_flag=0.
- Assert btn_ss and btn_lr edges in the same cycle from RUN → PAUSED, lap_hold=0. Drop rst_n mid-count → all outputs at reset values immediately.

Source files
------------

// File: rtl/stp_watch_ctrl.sv
// Stopwatch control sequencer: button edge detection, IDLE/RUN/LAP/PAUSED FSM,
// count-pulse prescaler, counter-clear pulse and sticky overflow flag.
module stp_watch_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       ovf,
  output logic       count_up_sec,
  output logic       rst_counters,
  output logic       lap_hold,
  output logic       running,
  output logic       ovf_flag,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    LAP    = 2'b10,
    PAUSED = 2'b11
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          btn_ss_q, btn_lr_q;
  logic          rst_counters_reg, rst_counters_next;
  logic          ovf_flag_reg, ovf_flag_next;
  logic          lap_hold_reg, running_reg;
  logic          ss_e, lr_e;

  assign ss_e = btn_ss & ~btn_ss_q;
  assign lr_e = btn_lr & ~btn_lr_q;

  // Priority: overflow (only while counting) > start/stop > lap/reset.
  // A present start/stop edge consumes the cycle even when it is ignored.
  always_comb begin
    state_next        = state_reg;
    rst_counters_next = 1'b0;
    ovf_flag_next     = ovf_flag_reg;
    if (running_reg && ovf) begin
      state_next    = PAUSED;
      ovf_flag_next = 1'b1;
    end else if (ss_e) begin
      case (state_reg)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSED;
        LAP:     state_next = PAUSED;
        PAUSED:  state_next = ovf_flag_reg ? PAUSED : RUN;
        default: state_next = IDLE;
      endcase
    end else if (lr_e) begin
      case (state_reg)
        IDLE:    rst_counters_next = 1'b1;
        RUN:     state_next = LAP;
        LAP:     state_next = RUN;
        PAUSED: begin
          state_next        = IDLE;
          rst_counters_next = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
    if (rst_counters_next)
      ovf_flag_next = 1'b0;

    // Prescaler advances on the cycles spent counting; holds while paused.
    if (state_next == IDLE)
      presc_next = '0;
    else if (running_reg)
      presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
    else
      presc_next = presc_reg;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      presc_reg        <= '0;
      btn_ss_q         <= 1'b0;
      btn_lr_q         <= 1'b0;
      rst_counters_reg <= 1'b0;
      ovf_flag_reg     <= 1'b0;
      lap_hold_reg     <= 1'b0;
      running_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      presc_reg        <= presc_next;
      btn_ss_q         <= btn_ss;
      btn_lr_q         <= btn_lr;
      rst_counters_reg <= rst_counters_next;
      ovf_flag_reg     <= ovf_flag_next;
      lap_hold_reg     <= (state_next == LAP);
      running_reg      <= (state_next == RUN) || (state_next == LAP);
    end
  end

  assign state        = state_reg;
  assign lap_hold     = lap_hold_reg;
  assign running      = running_reg;
  assign ovf_flag     = ovf_flag_reg;
  assign rst_counters = rst_counters_reg;
  assign count_up_sec = running_reg && (presc_reg == PRESC_LAST);

endmodule

// File: tb/tb_stp_watch_ctrl.sv
// Randomised and directed bench for stp_watch_ctrl against a behavioural model
// that tracks total counting cycles since the last clear.
module tb_stp_watch_ctrl;
  localparam int TD = 4;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_ss = 1'b0, btn_lr = 1'b0, ovf = 1'b0;
  logic       count_up_sec, rst_counters, lap_hold, running, ovf_flag;
  logic [1:0] state;
  logic [6:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 idle, 1 run, 2 lap, 3 paused; elapsed = counting cycles since clear
  int m_mode, m_elapsed;
  bit m_rc, m_of, m_pss, m_plr;

  stp_watch_ctrl #(.TICK_DIV(TD)) dut (
    .CLK(CLK), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lr(btn_lr), .ovf(ovf),
    .count_up_sec(count_up_sec), .rst_counters(rst_counters), .lap_hold(lap_hold),
    .running(running), .ovf_flag(ovf_flag), .state(state)
  );

  always #5 CLK = ~CLK;

  assign dut_vec = {state, running, lap_hold, count_up_sec, rst_counters, ovf_flag};

  function automatic logic [6:0] exp_vec();
    bit run;
    logic [1:0] md;
    run = (m_mode == 1) || (m_mode == 2);
    md  = 2'(m_mode);
    return {md, run, (m_mode == 2), run && ((m_elapsed % TD) == TD - 1), m_rc, m_of};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_rc = 0; m_of = 0; m_pss = 0; m_plr = 0;
  endtask

  task automatic model_step(input bit ss, input bit lr, input bit ov);
    bit ss_e, lr_e, run;
    int nm;
    ss_e = ss && !m_pss;
    lr_e = lr && !m_plr;
    run  = (m_mode == 1) || (m_mode == 2);
    nm   = m_mode;
    m_rc = 0;
    if (run && ov) begin
      nm = 3; m_of = 1;
    end else if (ss_e) begin
      if (m_mode == 0) nm = 1;
      else if (m_mode == 3) nm = m_of ? 3 : 1;
      else nm = 3;
    end else if (lr_e) begin
      if (m_mode == 0) m_rc = 1;
      else if (m_mode == 1) nm = 2;
      else if (m_mode == 2) nm = 1;
      else begin nm = 0; m_rc = 1; end
    end
    if (m_rc) m_of = 0;
    if (run) m_elapsed++;
    if (nm == 0) m_elapsed = 0;
    m_mode = nm;
    m_pss = ss;
    m_plr = lr;
  endtask

  // Inputs change on the falling edge; outputs are inspected on the falling edge.
  task automatic drive(input bit ss, input bit lr, input bit ov);
    btn_ss = ss; btn_lr = lr; ovf = ov;
    @(posedge CLK);
    model_step(ss, lr, ov);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== 7'b0) begin
      n_bad++; $display("FAIL reset_state: got %b expected %b", dut_vec, 7'b0);
    end
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    $display("reset released: outputs %b", dut_vec);
  endtask

  task automatic test_start_hold();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i < 10, 1'b0, 1'b0);
      pulses += int'(count_up_sec);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL start_hold[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (pulses !== 3) begin
      n_bad++; $display("FAIL start_pulse_count: got %0d expected 3", pulses);
    end
    $display("start_hold: state=%b pulses=%0d", state, pulses);
  endtask

  task automatic test_pause_resume();
    int guard = 0;
    while ((m_elapsed % TD) != 2 && guard < 10) begin
      drive(0, 0, 0); guard++;
    end
    n_cmp++;
    if (guard >= 10) begin
      n_bad++; $display("FAIL pause_align: got guard %0d expected < 10", guard);
    end
    for (int i = 0; i < 23; i++) begin
      drive(i == 0 || i == 22, 0, 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL pause_resume[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (count_up_sec !== 1'b1 || state !== 2'b01) begin
      n_bad++; $display("FAIL resume_first_pulse: got cu=%b st=%b expected cu=1 st=01", count_up_sec, state);
    end
    drive(0, 0, 0);
    $display("pause_resume: state=%b", state);
  endtask

  task automatic test_lap();
    for (int i = 0; i < 10; i++) begin
      drive(0, i == 1 || i == 7, 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL lap[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (i == 1) begin
        n_cmp++;
        if (state !== 2'b10 || lap_hold !== 1'b1) begin
          n_bad++; $display("FAIL lap_enter: got st=%b lh=%b expected st=10 lh=1", state, lap_hold);
        end
      end
    end
    n_cmp++;
    if (state !== 2'b01 || lap_hold !== 1'b0) begin
      n_bad++; $display("FAIL lap_exit: got st=%b lh=%b expected st=01 lh=0", state, lap_hold);
    end
    $display("lap: state=%b lap_hold=%b", state, lap_hold);
  endtask

  task automatic test_clear();
    int rc_count = 0;
    // pause, clear from PAUSED, then clear again from IDLE
    for (int i = 0; i < 10; i++) begin
      drive(i == 0, i == 2 || i == 6, 0);
      rc_count += int'(rst_counters);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL clear[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (rc_count !== 2 || state !== 2'b00) begin
      n_bad++; $display("FAIL clear_pulses: got rc=%0d st=%b expected rc=2 st=00", rc_count, state);
    end
    $display("clear: rst_counters pulses=%0d state=%b", rc_count, state);
  endtask

  task automatic test_ovf();
    for (int i = 0; i < 12; i++) begin
      drive(i == 0 || i == 5 || i == 7, i == 9, i == 5);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL ovf[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
      if (i == 8) begin
        n_cmp++;
        if (state !== 2'b11 || ovf_flag !== 1'b1) begin
          n_bad++; $display("FAIL ovf_locked: got st=%b of=%b expected st=11 of=1", state, ovf_flag);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (state !== 2'b00 || ovf_flag !== 1'b0 || rst_counters !== 1'b1) begin
          n_bad++; $display("FAIL ovf_clear: got st=%b of=%b rc=%b expected 00/0/1", state, ovf_flag, rst_counters);
        end
      end
    end
    $display("ovf: state=%b ovf_flag=%b", state, ovf_flag);
  endtask

  task automatic test_both_buttons();
    for (int i = 0; i < 6; i++) begin
      drive(i == 0 || i == 3, i == 3, 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL both[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (state !== 2'b11 || lap_hold !== 1'b0) begin
      n_bad++; $display("FAIL both_pause: got st=%b lh=%b expected st=11 lh=0", state, lap_hold);
    end
    drive(0, 1, 0);
    drive(0, 0, 0);
    $display("both_buttons: state=%b", state);
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL async_reset: got %b expected %b", dut_vec, exp_vec());
    end
    @(negedge CLK);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL post_reset[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    $display("async_reset: outputs %b", dut_vec);
  endtask

  task automatic test_random();
    bit ss = 0, lr = 0, ov;
    int bad_before = n_bad;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) ss = !ss;
      if ($urandom_range(4) == 0) lr = !lr;
      ov = ($urandom_range(11) == 0);
      drive(ss, lr, ov);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    $display("random: 400 cycles, %0d new mismatches", n_bad - bad_before);
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_pause_resume();
    test_lap();
    test_clear();
    test_ovf();
    test_both_buttons();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
